// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// FSM state encoding and requester identifiers.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Winner select for two requesters. Round-robin on ties by default;
// defining DMEM_ARB_FIXED_PRIO_EN makes m0 win every tie.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic i_m0_req,
  input  logic i_m1_req,
  input  logic i_ptr,
  output logic o_winner
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;
`endif

  // Pick the winner; i_ptr names the requester favoured on a tie
  always_comb begin
    o_winner = REQ_M0;
    if (i_m0_req && i_m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      o_winner = REQ_M0;
`else
      o_winner = i_ptr;
`endif
    end else if (i_m1_req) begin
      o_winner = REQ_M1;
    end else begin
      o_winner = REQ_M0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_WriteEnable,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_MemData,
  output logic              busy,
  output logic              grant_id
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;
  logic                w_access;
  logic                w_winner;
  logic                w_ptr;
  logic                r_we;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_grant;
  logic                r_busy;
  logic                r_m0_ack;
  logic                r_m1_ack;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_ptr = REQ_M0;
`else
  logic r_ptr;

  // Tie pointer: favour whichever requester did not win the last grant
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= REQ_M0;
    end else if (w_start) begin
      r_ptr <= ~w_winner;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  rr_arb2 u_rr_arb2 (
    .i_m0_req (m0_req),
    .i_m1_req (m1_req),
    .i_ptr    (w_ptr),
    .o_winner (w_winner)
  );

  assign w_start  = (r_state == ST_IDLE) && (m0_req || m1_req);
  assign w_access = (r_state == ST_ACCESS);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning request and drive the memory during ACCESS only
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_mem_we <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_grant  <= REQ_M0;
      r_busy   <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_mem_we <= 1'b0;
      if (w_start) begin
        r_grant  <= w_winner;
        r_we     <= (w_winner == REQ_M1) ? m1_we    : m0_we;
        r_mem_we <= (w_winner == REQ_M1) ? m1_we    : m0_we;
        r_addr   <= (w_winner == REQ_M1) ? m1_addr  : m0_addr;
        r_wdata  <= (w_winner == REQ_M1) ? m1_wdata : m0_wdata;
      end else begin
        r_grant  <= r_grant;
        r_we     <= r_we;
        r_addr   <= r_addr;
        r_wdata  <= r_wdata;
      end
    end
  end

  // Response: capture read data (or echo write data) and pulse the winner's ack
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= {DATA_W{1'b0}};
      r_m1_rdata <= {DATA_W{1'b0}};
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      if (w_access) begin
        if (r_grant == REQ_M1) begin
          r_m1_ack   <= 1'b1;
          r_m1_rdata <= r_we ? r_wdata : mem_MemData;
        end else begin
          r_m0_ack   <= 1'b1;
          r_m0_rdata <= r_we ? r_wdata : mem_MemData;
        end
      end else begin
        r_m0_rdata <= r_m0_rdata;
        r_m1_rdata <= r_m1_rdata;
      end
    end
  end

  assign mem_address     = r_addr;
  assign mem_WriteData   = r_wdata;
  assign mem_WriteEnable = r_mem_we;
  assign busy            = r_busy;
  assign grant_id        = r_grant;
  assign m0_ack          = r_m0_ack;
  assign m1_ack          = r_m1_ack;
  assign m0_rdata        = r_m0_rdata;
  assign m1_rdata        = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_WriteData, mem_MemData;
  logic        mem_WriteEnable, busy, grant_id;

  logic [31:0] tb_mem [32];
  logic [31:0] prev_rdata [2];
  int          n_chk  = 0;
  int          n_fail = 0;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam logic TIE_G = 1'b0;
`else
  localparam logic TIE_G = 1'b1;
`endif

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        exp_grant, exp_we;
    logic [31:0] exp_addr, exp_rdata;
  } vec_t;

  vec_t vecs [9];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_WriteEnable(mem_WriteEnable),
    .mem_WriteData(mem_WriteData), .mem_MemData(mem_MemData),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  assign mem_MemData = tb_mem[mem_address[6:2]];
  always @(posedge clock) begin
    if (mem_WriteEnable) tb_mem[mem_address[6:2]] <= mem_WriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clock);
    m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr; m1_wdata = v.m1_wdata;
    @(posedge clock); #1;
    $display("vec %0d: access phase", idx);
    chk("access_busy", {31'd0, busy}, 32'd1);
    chk("access_we", {31'd0, mem_WriteEnable}, {31'd0, v.exp_we});
    chk("access_addr", mem_address, v.exp_addr);
    chk("access_grant", {31'd0, grant_id}, {31'd0, v.exp_grant});
    chk("access_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    @(posedge clock); #1;
    chk("resp_acks", {30'd0, m1_ack, m0_ack}, v.exp_grant ? 32'd2 : 32'd1);
    chk("resp_rdata", v.exp_grant ? m1_rdata : m0_rdata, v.exp_rdata);
    chk("resp_other_rdata", v.exp_grant ? m0_rdata : m1_rdata, prev_rdata[~v.exp_grant]);
    chk("resp_we_low", {31'd0, mem_WriteEnable}, 32'd0);
    prev_rdata[v.exp_grant] = v.exp_rdata;
    @(posedge clock);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'h1000_0000 + i;
    tb_mem[0] = 32'd5;
    tb_mem[1] = 32'd6;
    prev_rdata[0] = 32'd0;
    prev_rdata[1] = 32'd0;

    // tie vectors: m0 reads 0x4 (=6), m1 reads 0x0 (=5)
    vecs[0] = '{1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 32'd6};
    vecs[1] = '{1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, TIE_G, 1'b0,
                TIE_G ? 32'h0 : 32'h4, TIE_G ? 32'd5 : 32'd6};
    vecs[2] = '{1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4, 32'd6};
    vecs[3] = vecs[1];
    vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1, 32'd5};
    vecs[7] = '{1'b1, 1'b1, 32'h10, 32'hA5A50001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 32'hA5A50001};
    vecs[8] = '{1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h13, 32'hA5A50001};

    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_WriteData, 32'd0);
    chk("rst_flags", {29'd0, mem_WriteEnable, busy, grant_id}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
    chk("mem_word2", tb_mem[2], 32'hDEADBEEF);
    chk("mem_word4", tb_mem[4], 32'hA5A50001);

    // idle: nothing moves for 10 cycles
    @(negedge clock);
    m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("idle_quiet", {28'd0, busy, m1_ack, m0_ack, mem_WriteEnable}, 32'd0);
    end

    // reset during ACCESS of an m1 write: write still lands, no ack
    @(negedge clock);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hC; m1_wdata = 32'h12345678;
    @(posedge clock); #1;
    chk("rstacc_grant", {31'd0, grant_id}, 32'd1);
    reset = 1'b1; m1_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rstacc_word3", tb_mem[3], 32'h12345678);
    chk("rstacc_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rstacc_busy_grant", {30'd0, busy, grant_id}, 32'd0);
    @(posedge clock); #1;
    chk("rstacc_noack_later", {30'd0, m1_ack, m0_ack}, 32'd0);

    // reset during RESP: ack seen this cycle, gone the next
    @(negedge clock);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rstresp_ack", {31'd0, m0_ack}, 32'd1);
    reset = 1'b1; m0_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rstresp_cancel", {29'd0, busy, m1_ack, m0_ack}, 32'd0);
    chk("rstresp_rdata", m0_rdata, 32'd0);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port word-addressed data memory, e.g. the CPU load/store path (m0) and a debug/DMA loader (m1).
- Latches the winning request, drives the memory for one cycle, and returns read data plus a one-cycle ack.
- Sits between the requesters and the data memory; the memory's combinational read and posedge write timing are unchanged.

Parameters:
- ADDR_W, 32, byte-address width passed to the memory.
- DATA_W, 32, data word width.

Ports:
- clock  in  1  system clock; all state on posedge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 transaction request; held until m0_ack
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  ADDR_W  requester 0 byte address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_ack  out  1  one-cycle completion pulse to requester 0
- m0_rdata  out  DATA_W  read data for requester 0, valid when m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as the m0 ports, for requester 1
- mem_address  out  ADDR_W  to memory address
- mem_WriteEnable  out  1  to memory WriteEnable
- mem_WriteData  out  DATA_W  to memory WriteData
- mem_MemData  in  DATA_W  from memory MemData (combinational read)
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  1  requester owning the current transaction; holds the last owner when idle

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner and latch its we/addr/wdata plus grant_id.
  - Next state ACCESS; otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr; mem_WriteData = latched wdata; mem_WriteEnable = latched we.
  - The memory write commits at the closing edge.
  - At that edge, capture mem_MemData into the rdata register for reads.
  - Next state RESP.
- RESP (1 cycle):
  - Winner's ack = 1; its rdata = captured word. On a write, rdata = the written wdata.
  - Next state IDLE unconditionally.
- Latency and throughput: req sampled at edge N → ACCESS in cycle N+1 → ack in cycle N+2. Maximum rate is one transaction per 3 cycles.
- Outside ACCESS: mem_WriteEnable = 0. mem_address and mem_WriteData hold their last latched values, with no glitching to requester inputs.
- Non-winner ack stays 0. Its rdata holds its previous value.
- Arbitration is round-robin with a 1-bit pointer:
  - Single req wins outright.
  - With both req high, the requester not granted last wins.
  - The pointer updates when entering ACCESS.
- Handshake:
  - Requester holds req and payload stable until ack.
  - req dropped before ack is a protocol error and is not checked. The latched copy is used regardless.
  - req still high in the cycle after ack is treated as a new request.
- Address handling: addresses pass through unmodified. The memory uses word index addr[6:2]; low bits [1:0] are ignored, with no alignment fault.
- Reset values: state IDLE, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, mem_address=0, mem_WriteData=0, mem_WriteEnable=0, busy=0, grant_id=0, pointer favours m0.
- Reset mid-operation:
  - Reset asserted during ACCESS does not suppress that cycle's write, since WriteEnable was already presented to the memory.
  - No ack is issued; the next state is IDLE.
  - Reset during RESP cancels the ack from the following cycle onward. The current-cycle ack has already been seen.
- Simultaneous events: reset has priority over every FSM transition.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 always wins a tie. The pointer logic is removed and m1 can starve.
- Undefined: round-robin as specified above.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - requester ids: REQ_M0=1'b0, REQ_M1=1'b1.
- Sub-module rr_arb2: pure winner select from {m1_req, m0_req, pointer}. Combinational, about 20 lines; the macro is applied there.

Test Plan:
- Reset, then m0 read addr 0x4 with memory word1=6 → ack at cycle 2 after sampling, m0_rdata=6, mem_WriteEnable never 1.
- m1 write addr 0x8, data 0xDEADBEEF, then m1 read 0x8 → WriteEnable high only in ACCESS, m1_rdata=0xDEADBEEF, m0_ack stays 0.
- Both req held high for 4 transactions → grants alternate M0,M1,M0,M1 (m0 first after reset); with DMEM_ARB_FIXED_PRIO_EN → all M0.
- m0 read addr 0x1 (misaligned) with word0=5 → m0_rdata=5.
- Reset asserted in an ACCESS cycle of a write of 0x12345678 to 0xC → word3 = 0x12345678 afterwards, no ack, busy=0 next cycle, grant_id=0.
- No requests for 10 cycles → state stays IDLE, busy=0, both acks 0, mem_WriteEnable=0.
